cmp_tally: RTL and testbench

Downstream consumer of the 8-bit comparator/encoder stage. Each cycle it may accept one 2-bit compare code (01 = in1>in2, 10 = equal, 00 = in1<in2) and tallies the codes over a fixed window of WIN accepted samples. At the end of each window it reports the three counts, an error count and the majority outcome, then returns to idle until the next start. It turns a per-pair compare result into a window-level statistic for the control logic that follows.

---
 rtl/cmp_tally.sv | 141 ++++++++++++++
 tb/tb_cmp_tally.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cmp_tally.sv
// rtl/cmp_tally.sv - windowed tally of comparator codes with majority report
// Counts gt/eq/lt/illegal codes over WIN accepted samples, then pulses done with the majority.

module cmp_tally #(
   parameter int WIN   = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       code,
   input  logic             code_valid,
   output logic             code_ready,
   output logic             busy,
   output logic [CNT_W-1:0] gt_cnt,
   output logic [CNT_W-1:0] eq_cnt,
   output logic [CNT_W-1:0] lt_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [1:0]       majority,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_COUNT  = 2'd1,
      S_REPORT = 2'd2
   } state_t;

   localparam logic [1:0]       CODE_LT = 2'b00;
   localparam logic [1:0]       CODE_GT = 2'b01;
   localparam logic [1:0]       CODE_EQ = 2'b10;
   localparam logic [CNT_W-1:0] ZERO    = '0;
   localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIN - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] gt_q, gt_d, eq_q, eq_d, lt_q, lt_d, err_q, err_d;
   logic [CNT_W-1:0] n_q, n_d;
   logic [1:0]       maj_q, maj_d;
   logic             ready_q, ready_d, busy_q, busy_d, done_q, done_d;

   // Ties resolve eq > gt > lt; an all-zero window therefore reports eq.
   function automatic logic [1:0] pick_majority(input logic [CNT_W-1:0] g,
                                                input logic [CNT_W-1:0] e,
                                                input logic [CNT_W-1:0] l);
      if (e >= g && e >= l)
         return CODE_EQ;
      else if (g >= l)
         return CODE_GT;
      else
         return CODE_LT;
   endfunction

   always_comb begin
      state_d = state_q;
      gt_d    = gt_q;
      eq_d    = eq_q;
      lt_d    = lt_q;
      err_d   = err_q;
      n_d     = n_q;
      maj_d   = maj_q;
      ready_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               gt_d    = ZERO;
               eq_d    = ZERO;
               lt_d    = ZERO;
               err_d   = ZERO;
               n_d     = ZERO;
               state_d = S_COUNT;
               ready_d = 1'b1;
               busy_d  = 1'b1;
            end
         end
         S_COUNT: begin
            ready_d = 1'b1;
            busy_d  = 1'b1;
            if (code_valid) begin
               case (code)
                  CODE_GT: gt_d  = gt_q + ONE;
                  CODE_EQ: eq_d  = eq_q + ONE;
                  CODE_LT: lt_d  = lt_q + ONE;
                  default: err_d = err_q + ONE;
               endcase
               n_d = n_q + ONE;
               if (n_q == LAST) begin
                  state_d = S_REPORT;
                  ready_d = 1'b0;
                  done_d  = 1'b1;
                  maj_d   = pick_majority(gt_d, eq_d, lt_d);
               end
            end
         end
         S_REPORT: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         gt_q    <= '0;
         eq_q    <= '0;
         lt_q    <= '0;
         err_q   <= '0;
         n_q     <= '0;
         maj_q   <= CODE_LT;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gt_q    <= gt_d;
         eq_q    <= eq_d;
         lt_q    <= lt_d;
         err_q   <= err_d;
         n_q     <= n_d;
         maj_q   <= maj_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign code_ready = ready_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign gt_cnt     = gt_q;
   assign eq_cnt     = eq_q;
   assign lt_cnt     = lt_q;
   assign err_cnt    = err_q;
   assign majority   = maj_q;

endmodule

// File: tb/tb_cmp_tally.sv
// tb/tb_cmp_tally.sv - directed bench for cmp_tally
// Inputs change 1 ns after each rising edge; outputs are sampled at the same point.

module tb_cmp_tally;

   localparam int WIN   = 16;
   localparam int CNT_W = 5;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [1:0]       code;
   logic             code_valid;
   logic             code_ready;
   logic             busy;
   logic [CNT_W-1:0] gt_cnt, eq_cnt, lt_cnt, err_cnt;
   logic [1:0]       majority;
   logic             done;

   int checks = 0;
   int errors = 0;

   cmp_tally #(.WIN(WIN), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .code       (code),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .busy       (busy),
      .gt_cnt     (gt_cnt),
      .eq_cnt     (eq_cnt),
      .lt_cnt     (lt_cnt),
      .err_cnt    (err_cnt),
      .majority   (majority),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_counts(input string tag, input int g, input int e, input int l,
                               input int x);
      check({tag, " gt"},  32'(gt_cnt),  32'(g));
      check({tag, " eq"},  32'(eq_cnt),  32'(e));
      check({tag, " lt"},  32'(lt_cnt),  32'(l));
      check({tag, " err"}, 32'(err_cnt), 32'(x));
   endtask

   logic [1:0] seq_tie [16];

   initial begin
      // tie window: 6 gt, 6 eq, 3 lt, 1 illegal, interleaved
      seq_tie = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10,
                  2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10};

      rst_n = 1'b0; start = 1'b0; code = 2'b01; code_valid = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      check("rst ready", 32'(code_ready), 0);
      check("rst busy", 32'(busy), 0);
      check("rst done", 32'(done), 0);
      check("rst maj", 32'(majority), 0);
      check_counts("rst", 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("idle done", 32'(done), 0);
         check("idle ready", 32'(code_ready), 0);
         check("idle gt", 32'(gt_cnt), 0);
      end

      // Full window, back-to-back
      code_valid = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("w1 ready", 32'(code_ready), 1);
      check("w1 busy", 32'(busy), 1);
      for (int i = 0; i < WIN; i++) begin
         code_valid = 1'b1;
         code = (i < 10) ? 2'b01 : (i < 14) ? 2'b10 : 2'b00;
         tick();
         if (i < WIN - 1) check("w1 early done", 32'(done), 0);
         if (i == 4) check("w1 mid gt", 32'(gt_cnt), 5);
      end
      code_valid = 1'b0;
      check("w1 done", 32'(done), 1);
      check("w1 ready rpt", 32'(code_ready), 0);
      check("w1 busy rpt", 32'(busy), 1);
      check("w1 maj", 32'(majority), 32'h1);
      check_counts("w1", 10, 4, 2, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("w1 done off", 32'(done), 0);
      check("w1 busy off", 32'(busy), 0);
      check("w1 no restart", 32'(code_ready), 0);
      check_counts("w1 hold", 10, 4, 2, 0);

      // Tie window with bubbles, illegal code, start during COUNT
      start = 1'b1;
      tick();
      start = 1'b0;
      check_counts("w2 clear", 0, 0, 0, 0);
      for (int i = 0; i < WIN; i++) begin
         code_valid = 1'b0;
         code = 2'b11;
         tick();
         check("w2 bubble done", 32'(done), 0);
         code_valid = 1'b1;
         code = seq_tie[i];
         start = (i == 3);
         tick();
         start = 1'b0;
         if (i < WIN - 1) check("w2 early done", 32'(done), 0);
         if (i == 5) check_counts("w2 mid", 2, 2, 1, 1);
      end
      code_valid = 1'b0;
      check("w2 done", 32'(done), 1);
      check("w2 maj", 32'(majority), 32'h2);
      check_counts("w2", 6, 6, 3, 1);
      tick();
      check("w2 done off", 32'(done), 0);
      check("w2 busy off", 32'(busy), 0);
      for (int i = 0; i < 3; i++) tick();
      check_counts("w2 hold", 6, 6, 3, 1);
      check("w2 maj hold", 32'(majority), 32'h2);

      // Reset mid-window after 7 accepts
      start = 1'b1;
      tick();
      start = 1'b0;
      check_counts("w3 clear", 0, 0, 0, 0);
      code = 2'b01;
      code_valid = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      check("w3 gt7", 32'(gt_cnt), 7);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      code_valid = 1'b0;
      check("w3 rst ready", 32'(code_ready), 0);
      check("w3 rst busy", 32'(busy), 0);
      check("w3 rst done", 32'(done), 0);
      check("w3 rst maj", 32'(majority), 0);
      check_counts("w3 rst", 0, 0, 0, 0);
      tick();
      check("w3 rst done2", 32'(done), 0);

      // Fresh window, all illegal
      start = 1'b1;
      tick();
      start = 1'b0;
      check("w4 ready", 32'(code_ready), 1);
      code = 2'b11;
      code_valid = 1'b1;
      for (int i = 0; i < WIN; i++) tick();
      code_valid = 1'b0;
      check("w4 done", 32'(done), 1);
      check("w4 maj", 32'(majority), 32'h2);
      check_counts("w4", 0, 0, 0, 16);
      tick();
      check("w4 done off", 32'(done), 0);
      check("w4 busy off", 32'(busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
